// File: rtl/noc_rsp_collector_if.sv
// noc_rsp_collector_if: router-side packet input and ant-side delivery handshake.
interface noc_rsp_collector_if #(
    parameter int WIDTH = 16
);
    localparam int PKT_W = WIDTH + 8;
    logic             writeOut;
    logic [PKT_W-1:0] dataOut;
    logic             full;
    logic             almost_full;
    logic             response_valid;
    logic [WIDTH-1:0] response;
    logic [5:0]       response_page;
    logic             response_ready;
    modport master (
        output writeOut, dataOut, response_ready,
        input  full, almost_full, response_valid, response, response_page
    );
    modport slave (
        input  writeOut, dataOut, response_ready,
        output full, almost_full, response_valid, response, response_page
    );
endinterface

// File: rtl/noc_rsp_collector.sv
// noc_rsp_collector: matches response packets against outstanding page requests and queues them for the ant.
// Optional saturating accept/drop counters are enabled by NOC_RSP_COLLECT_STATS_EN.
module noc_rsp_collector #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int PKT_W = WIDTH + 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         node_id,
    noc_rsp_collector_if.slave rx,
    input  logic               req_issue,
    input  logic [5:0]         req_page,
    output logic [6:0]         pending_cnt,
    output logic               err,
    output logic [15:0]        stat_accepted,
    output logic [15:0]        stat_dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_CNT = (AW + 1)'(DEPTH - 1);
    logic [PKT_W-1:0] pkt;
    logic [1:0]       dst;
    logic [5:0]       page;
    logic [WIDTH-1:0] val;
    logic [63:0]      pend;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic [WIDTH+5:0] mem [DEPTH];
    logic             accept, drop, pop, inc;

    assign pkt = rx.dataOut;
    assign {dst, page, val} = pkt;
    assign rx.full = cnt == FULL_CNT;
    assign rx.almost_full = cnt >= AF_CNT;
    assign accept = rx.writeOut && dst == node_id && pend[page] && !rx.full;
    assign drop = rx.writeOut && !accept;
    assign pop = rx.response_valid && rx.response_ready;
    // A same-cycle issue for the page being accepted re-arms it, so it still counts as a new request
    assign inc = req_issue && (!pend[req_page] || (accept && page == req_page));
    assign rx.response_valid = cnt != '0;
    assign {rx.response_page, rx.response} = rx.response_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pend        <= '0;
            pending_cnt <= '0;
            cnt         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            err         <= 1'b0;
        end else begin
            pend        <= (pend & ~(64'(accept) << page)) | (64'(req_issue) << req_page);
            pending_cnt <= pending_cnt + 7'(inc) - 7'(accept);
            cnt         <= cnt + (AW + 1)'(accept) - (AW + 1)'(pop);
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (drop) err <= 1'b1;
        end

    always_ff @(posedge clk)
        if (accept) mem[wr_ptr] <= {page, val};

`ifdef NOC_RSP_COLLECT_STATS_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            stat_accepted <= '0;
            stat_dropped  <= '0;
        end else begin
            if (accept && stat_accepted != 16'hFFFF) stat_accepted <= stat_accepted + 1'b1;
            if (drop && stat_dropped != 16'hFFFF) stat_dropped <= stat_dropped + 1'b1;
        end
`else
    assign stat_accepted = '0;
    assign stat_dropped  = '0;
`endif
endmodule

// File: tb/tb_noc_rsp_collector.sv
// tb_noc_rsp_collector: vector table plus hand sequences, delivered data checked against a scoreboard queue.
module tb_noc_rsp_collector;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  node_id;
    logic        req_issue;
    logic [5:0]  req_page;
    logic [6:0]  pending_cnt;
    logic        err;
    logic [15:0] stat_accepted, stat_dropped;
    int          checks = 0;
    int          errors = 0;
    logic [21:0] sb [$];

    noc_rsp_collector_if #(.WIDTH(16)) bus ();

    noc_rsp_collector #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .node_id(node_id), .rx(bus.slave),
        .req_issue(req_issue), .req_page(req_page), .pending_cnt(pending_cnt),
        .err(err), .stat_accepted(stat_accepted), .stat_dropped(stat_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iss;
        logic [5:0]  ipg;
        logic        wr;
        logic [1:0]  dst;
        logic [5:0]  pg;
        logic [15:0] val;
        logic        rdy;
        logic        acc;
        logic [6:0]  e_pcnt;
        logic        e_valid;
        logic        e_af;
        logic        e_full;
        logic        e_err;
    } vec_t;
    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Drive one cycle starting just after a rising edge; any pop is checked before the edge.
    task automatic cyc(input logic iss, input logic [5:0] ipg, input logic wr, input logic [1:0] dst,
                       input logic [5:0] pg, input logic [15:0] val, input logic rdy, input logic acc);
        logic [21:0] e;
        req_issue = iss;
        req_page = ipg;
        bus.writeOut = wr;
        bus.dataOut = {dst, pg, val};
        bus.response_ready = rdy;
        #1;
        if (bus.response_valid && rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected got %h want none", {bus.response_page, bus.response});
            end else begin
                e = sb.pop_front();
                chk("pop_data", {bus.response_page, bus.response}, e);
            end
        end
        if (acc) sb.push_back({pg, val});
        @(posedge clk);
        #1;
        req_issue = 1'b0;
        bus.writeOut = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_issue = 1'b0;
        bus.writeOut = 1'b0;
        bus.response_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
    endtask

    initial begin
        node_id = 2'd2;
        req_page = '0;
        bus.dataOut = '0;
        //          iss ipg wr dst pg  val       rdy acc pcnt v af full err
        vt[0]  = '{1, 5, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 1, 2, 5, 16'h1234, 0, 1, 0, 1, 0, 0, 0};
        vt[2]  = '{0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 0};
        vt[3]  = '{0, 0, 1, 2, 9, 16'hDEAD, 1, 0, 0, 0, 0, 0, 1};
        vt[4]  = '{1, 9, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 1};
        vt[5]  = '{0, 0, 1, 1, 9, 16'h1111, 1, 0, 1, 0, 0, 0, 1};
        vt[6]  = '{0, 0, 1, 2, 9, 16'hBEEF, 0, 1, 0, 1, 0, 0, 1};
        vt[7]  = '{0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 1};
        vt[8]  = '{1, 7, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 1};
        vt[9]  = '{1, 7, 1, 2, 7, 16'h7777, 0, 1, 1, 1, 0, 0, 1};
        vt[10] = '{0, 0, 1, 2, 7, 16'h7778, 1, 1, 0, 1, 0, 0, 1};
        vt[11] = '{0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 1};
        vt[12] = '{1, 3, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 1};
        vt[13] = '{1, 3, 0, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 1};
        vt[14] = '{0, 0, 1, 2, 3, 16'h3333, 1, 1, 0, 1, 0, 0, 1};
        vt[15] = '{0, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 1};

        do_reset();
        chk("rst_pcnt", pending_cnt, 0);
        chk("rst_valid", bus.response_valid, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_af", bus.almost_full, 0);
        chk("rst_err", err, 0);
        chk("rst_resp", {bus.response_page, bus.response}, 0);

        for (int i = 0; i < 16; i++) begin
            cyc(vt[i].iss, vt[i].ipg, vt[i].wr, vt[i].dst, vt[i].pg, vt[i].val, vt[i].rdy, vt[i].acc);
            chk($sformatf("v%0d_pcnt", i), pending_cnt, vt[i].e_pcnt);
            chk($sformatf("v%0d_valid", i), bus.response_valid, vt[i].e_valid);
            chk($sformatf("v%0d_af", i), bus.almost_full, vt[i].e_af);
            chk($sformatf("v%0d_full", i), bus.full, vt[i].e_full);
            chk($sformatf("v%0d_err", i), err, vt[i].e_err);
        end
`ifdef NOC_RSP_COLLECT_STATS_EN
        chk("stat_acc_tbl", stat_accepted, 5);
        chk("stat_drop_tbl", stat_dropped, 2);
`endif

        // Fill the FIFO; the fifth packet arrives while full and must be dropped even with a pop.
        do_reset();
        chk("rst2_err", err, 0);
        for (int i = 0; i < 5; i++) cyc(1, 6'(i), 0, 0, 0, 0, 0, 0);
        chk("full_pcnt_issued", pending_cnt, 5);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 2, 6'(i), 16'(16'hA000 + i), 0, 1);
            chk($sformatf("fill%0d_af", i), bus.almost_full, i >= 2);
            chk($sformatf("fill%0d_full", i), bus.full, i == 3);
            chk($sformatf("fill%0d_pcnt", i), pending_cnt, 4 - i);
        end
        cyc(0, 0, 1, 2, 4, 16'hA004, 1, 0);
        chk("full_drop_err", err, 1);
        chk("full_drop_pcnt", pending_cnt, 1);
        chk("full_drop_full", bus.full, 0);
        chk("full_drop_af", bus.almost_full, 1);
        cyc(0, 0, 1, 2, 4, 16'hA004, 0, 1);
        chk("retry_pcnt", pending_cnt, 0);
        chk("retry_full", bus.full, 1);

        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("hold%0d_resp", i), bus.response, 16'hA001);
            chk($sformatf("hold%0d_page", i), bus.response_page, 1);
            chk($sformatf("hold%0d_valid", i), bus.response_valid, 1);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("drain_valid", bus.response_valid, 0);

        for (int i = 0; i < 10; i++) cyc(1, 6'(10 + i), 0, 0, 0, 0, 1, 0);
        chk("stream_pcnt_issued", pending_cnt, 10);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 2, 6'(10 + i), 16'(16'h5000 + i * 17), 1, 1);
            chk($sformatf("stream%0d_valid", i), bus.response_valid, 1);
            chk($sformatf("stream%0d_full", i), bus.full, 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("stream_end_valid", bus.response_valid, 0);
        chk("stream_end_pcnt", pending_cnt, 0);
        chk("stream_sb_empty", sb.size(), 0);

        // Asynchronous reset with 3 queued entries and 5 pages pending.
        for (int i = 0; i < 8; i++) cyc(1, 6'(20 + i), 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 2, 6'(20 + i), 16'(16'hC000 + i), 0, 1);
        chk("pre_rst_pcnt", pending_cnt, 5);
        chk("pre_rst_valid", bus.response_valid, 1);
        reset = 1'b0;
        #1;
        chk("arst_pcnt", pending_cnt, 0);
        chk("arst_valid", bus.response_valid, 0);
        chk("arst_full", bus.full, 0);
        chk("arst_af", bus.almost_full, 0);
        chk("arst_err", err, 0);
        chk("arst_resp", {bus.response_page, bus.response}, 0);
        chk("arst_stats", {stat_accepted, stat_dropped}, 0);
        #2 reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        cyc(0, 0, 1, 2, 23, 16'hC003, 1, 0);
        chk("post_rst_err", err, 1);
        chk("post_rst_valid", bus.response_valid, 0);
        chk("post_rst_pcnt", pending_cnt, 0);
`ifdef NOC_RSP_COLLECT_STATS_EN
        chk("stat_drop_post", stat_dropped, 1);
        chk("stat_acc_post", stat_accepted, 0);
`endif
        chk("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
